if_stage: RTL and testbench



---
 rtl/if_stage_pkg.sv | 22 ++
 rtl/if_stage_if_id_reg.sv | 34 +++
 rtl/if_stage.sv | 162 ++++++++++++++++
 tb/tb_if_stage.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared constants and fetch FSM encoding for the IF stage
package if_stage_pkg;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [63:0] RESET_PC_DEF  = 64'h0000_0000_0000_0000;

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef enum logic [1:0] {
        S_REQ  = ST_REQ,
        S_WAIT = ST_WAIT,
        S_HOLD = ST_HOLD
    } fetch_state_t;

    // Instructions are word aligned; the low two bits of any target are dropped.
    function automatic logic [63:0] align_pc(input logic [63:0] pc);
        return pc & ~64'd3;
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// rtl/if_stage_if_id_reg.sv - IF/ID pipeline register with load, bubble and hold controls
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] instr_in,
    input  logic [63:0] pc_in,
    output logic [31:0] instruction_D,
    output logic [63:0] PC_D,
    output logic        valid_D
);

    // A bubble keeps PC_D so decode still sees the last real PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instruction_D <= NOP_INSTR;
            PC_D          <= '0;
            valid_D       <= 1'b0;
        end else if (bubble) begin
            instruction_D <= NOP_INSTR;
            valid_D       <= 1'b0;
        end else if (load) begin
            instruction_D <= instr_in;
            PC_D          <= pc_in;
            valid_D       <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - fetch stage: PC, single-outstanding imem handshake, IF/ID (option IF_MISALIGN_CHK_EN)
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_D,
    input  logic        flush_D,
    input  logic        redirect_en,
    input  logic [63:0] redirect_pc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_D,
    output logic [63:0] PC_D,
    output logic        valid_D,
    output logic        fetch_misaligned
);

    fetch_state_t state, state_n;
    logic [63:0]  pc_f, pc_n, pc_inc;
    logic         kill, kill_n, req_n;
    logic         buf_valid, buf_valid_n;
    logic [31:0]  buf_instr, buf_instr_n, idr_instr;
    logic [63:0]  buf_pc, buf_pc_n, idr_pc;
    logic         idr_load, idr_bubble;

    assign pc_inc    = pc_f + 64'd4;
    assign imem_addr = pc_f;

    always_comb begin
        state_n     = state;
        pc_n        = pc_f;
        kill_n      = kill;
        req_n       = imem_req;
        buf_valid_n = buf_valid;
        buf_instr_n = buf_instr;
        buf_pc_n    = buf_pc;
        idr_load    = 1'b0;
        idr_bubble  = 1'b0;
        idr_instr   = imem_rdata;
        idr_pc      = pc_f;

        case (state)
            S_REQ: begin
                req_n   = 1'b1;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (imem_ack) begin
                    req_n = 1'b0;
                    if (kill) begin
                        kill_n  = 1'b0;
                        state_n = S_REQ;
                    end else if (stall_D || flush_D) begin
                        // Decode cannot take it now; park it rather than refetch.
                        buf_valid_n = 1'b1;
                        buf_instr_n = imem_rdata;
                        buf_pc_n    = pc_f;
                        pc_n        = pc_inc;
                        state_n     = S_HOLD;
                    end else begin
                        idr_load = 1'b1;
                        pc_n     = pc_inc;
                        state_n  = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (buf_valid && !stall_D && !flush_D) begin
                    idr_load    = 1'b1;
                    idr_instr   = buf_instr;
                    idr_pc      = buf_pc;
                    buf_valid_n = 1'b0;
                    state_n     = S_REQ;
                end
            end
            default: begin
                req_n   = 1'b0;
                state_n = S_REQ;
            end
        endcase

        if (flush_D) begin
            idr_load   = 1'b0;
            idr_bubble = 1'b1;
        end else if (!stall_D && !idr_load) begin
            idr_bubble = 1'b1;
        end

        // A redirect outranks everything: the response in flight is stale.
        if (redirect_en) begin
            pc_n        = align_pc(redirect_pc);
            buf_valid_n = 1'b0;
            idr_load    = 1'b0;
            idr_bubble  = 1'b1;
            if (state == S_WAIT) begin
                if (imem_ack) begin
                    kill_n  = 1'b0;
                    state_n = S_REQ;
                end else begin
                    kill_n = 1'b1;
                end
            end
            if (state == S_HOLD) state_n = S_REQ;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_REQ;
            pc_f      <= RESET_PC;
            kill      <= 1'b0;
            imem_req  <= 1'b0;
            buf_valid <= 1'b0;
            buf_instr <= NOP_INSTR;
            buf_pc    <= '0;
        end else begin
            state     <= state_n;
            pc_f      <= pc_n;
            kill      <= kill_n;
            imem_req  <= req_n;
            buf_valid <= buf_valid_n;
            buf_instr <= buf_instr_n;
            buf_pc    <= buf_pc_n;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk           (clk),
        .reset         (reset),
        .load          (idr_load),
        .bubble        (idr_bubble),
        .instr_in      (idr_instr),
        .pc_in         (idr_pc),
        .instruction_D (instruction_D),
        .PC_D          (PC_D),
        .valid_D       (valid_D)
    );

`ifdef IF_MISALIGN_CHK_EN
    logic misaligned_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            misaligned_q <= 1'b0;
        else if (redirect_en && (redirect_pc[1:0] != 2'b00))
            misaligned_q <= 1'b1;
    end

    assign fetch_misaligned = misaligned_q;
`else
    assign fetch_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized scoreboard bench for if_stage
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_D, flush_D, redirect_en;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction_D;
    logic [63:0] PC_D;
    logic        valid_D;
    logic        fetch_misaligned;

    int n_checks = 0;
    int n_fails  = 0;
    int n_entries = 0;

    if_stage dut (
        .clk              (clk),
        .reset            (reset),
        .stall_D          (stall_D),
        .flush_D          (flush_D),
        .redirect_en      (redirect_en),
        .redirect_pc      (redirect_pc),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ack         (imem_ack),
        .imem_rdata       (imem_rdata),
        .instruction_D    (instruction_D),
        .PC_D             (PC_D),
        .valid_D          (valid_D),
        .fetch_misaligned (fetch_misaligned)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_t;

    // Accepted responses that decode has not yet received, in program order.
    fetch_t      exp_q[$];
    logic [63:0] fetch_pc;
    logic        exp_mis;

    logic        mem_busy, mem_disc;
    logic [63:0] mem_addr;
    int          mem_cnt;
    int          phase;
    int          stall_left;
    logic [4:0]  done;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'h0:   return 32'h0020_8133;
            64'h4:   return 32'h0100_0093;
            64'h8:   return 32'h0011_2023;
            default: return a[33:2] ^ a[63:32] ^ 32'hA5C3_0F00;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_values();
        chk("rst_instr", instruction_D, NOP);
        chk("rst_pc_d", PC_D, 64'h0);
        chk("rst_valid", valid_D, 1'b0);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_mis", fetch_misaligned, 1'b0);
    endtask

    // One cycle of memory model, stimulus and reference-model update at the negedge.
    task automatic stim_cycle();
        logic        cap, ack_now, stray, st, fl, rd;
        logic [63:0] rt;
        fetch_t      it;
        @(negedge clk);
        cap = 0; ack_now = 0; stray = 0; st = 0; fl = 0; rd = 0; rt = {$urandom, $urandom};
        if (exp_q.size() != 0) chk("no_req_in_hold", imem_req, 1'b0);
        if (!mem_busy && imem_req) begin
            chk("imem_addr", imem_addr, fetch_pc);
            mem_busy = 1; mem_addr = imem_addr; mem_disc = 0; cap = 1;
            if (phase == 0) mem_cnt = (imem_addr == 64'hC && !done[1]) ? 2 : 0;
            else            mem_cnt = $urandom_range(0, 2);
        end else if (mem_busy) begin
            chk("req_held", imem_req, 1'b1);
        end
        if (mem_busy) begin
            if (mem_cnt == 0) ack_now = 1;
            else mem_cnt--;
        end
        if (phase == 0) begin
            if (ack_now && mem_addr == 64'h8 && !done[0]) begin done[0] = 1; stall_left = 3; end
            if (cap && mem_addr == 64'hC && !done[1]) begin done[1] = 1; rd = 1; rt = 64'h40; end
            if (ack_now && mem_addr == 64'h48 && !done[2]) begin done[2] = 1; st = 1; fl = 1; end
            if (cap && mem_addr == 64'h50 && !done[3]) begin
                done[3] = 1; rd = 1; rt = 64'hFFFF_FFFF_FFFF_FFF8;
            end
            if (cap && mem_addr == 64'h10 && done[3] && !done[4]) begin done[4] = 1; rd = 1; rt = 64'h42; end
            if (stall_left > 0) begin st = 1; stall_left--; end
        end else begin
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 9) == 0);
            rd = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 2))
                0:       rt = {52'h0, 12'($urandom)};
                1:       rt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
                default: rt = {$urandom, $urandom};
            endcase
            stray = !mem_busy && !imem_req && ($urandom_range(0, 3) == 0);
        end
        if (rd && mem_busy) mem_disc = 1;
        imem_ack = 0;
        imem_rdata = $urandom;
        if (ack_now) begin
            imem_ack = 1;
            imem_rdata = mem_word(mem_addr);
            mem_busy = 0;
            if (!mem_disc) begin
                it.pc = mem_addr; it.instr = mem_word(mem_addr);
                exp_q.push_back(it);
                fetch_pc = fetch_pc + 64'd4;
            end
        end else if (stray) begin
            imem_ack = 1;
        end
        if (rd) begin
            exp_q.delete();
            fetch_pc = rt & ~64'd3;
`ifdef IF_MISALIGN_CHK_EN
            if (rt[1:0] != 2'b00) exp_mis = 1;
`endif
        end
        stall_D = st; flush_D = fl; redirect_en = rd; redirect_pc = rt;
    endtask

    // Monitor: decides at each edge what IF/ID must hold, checks it just after.
    initial begin : monitor
        logic        s, f, r;
        fetch_t      it;
        logic [31:0] e_instr;
        logic [63:0] e_pc;
        logic        e_valid;
        e_instr = NOP; e_pc = '0; e_valid = 0;
        forever begin
            @(posedge clk);
            s = stall_D; f = flush_D; r = redirect_en;
            if (!reset) begin
                if (r || f) begin
                    e_instr = NOP; e_valid = 0;
                end else if (!s) begin
                    if (exp_q.size() > 0) begin
                        it = exp_q.pop_front();
                        e_instr = it.instr; e_pc = it.pc; e_valid = 1;
                        n_entries++;
                    end else begin
                        e_instr = NOP; e_valid = 0;
                    end
                end
            end
            #1;
            if (reset) begin e_instr = NOP; e_pc = '0; e_valid = 0; end
            chk("instruction_D", instruction_D, e_instr);
            chk("PC_D", PC_D, e_pc);
            chk("valid_D", valid_D, e_valid);
            chk("fetch_misaligned", fetch_misaligned, exp_mis);
        end
    end

    initial begin : stim
        reset = 1; stall_D = 0; flush_D = 0; redirect_en = 0; redirect_pc = '0;
        imem_ack = 0; imem_rdata = '0;
        fetch_pc = 64'h0; exp_mis = 0; mem_busy = 0; mem_disc = 0; mem_addr = '0; mem_cnt = 0;
        phase = 0; stall_left = 0; done = '0;
        repeat (3) @(negedge clk);
        chk_reset_values();
        reset = 0;

        repeat (300) stim_cycle();
        chk("directed_done", done, 5'h1F);

        phase = 1;
        repeat (3000) stim_cycle();

        begin
            int k = 0;
            while (!mem_busy && k < 50) begin stim_cycle(); k++; end
            chk("reach_wait", mem_busy, 1'b1);
        end
        #2 reset = 1;
        stall_D = 0; flush_D = 0; redirect_en = 0; imem_ack = 0;
        mem_busy = 0; exp_q.delete(); fetch_pc = 64'h0; exp_mis = 0;
        #1 chk_reset_values();
        @(negedge clk);
        @(negedge clk);
        reset = 0;

        repeat (500) stim_cycle();
        chk("enough_deliveries", 64'(n_entries >= 100), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
